ahb_mtx_in_stage: RTL and testbench
===================================

Name: ahb_mtx_in_stage

Overview:
- Master-side input stage of the AHB bus matrix: one instance per master port, ahead of the per-slave output arbiters.
- Accepts master address phases and forwards them directly when this port is granted by the target output stage.
- Otherwise holds the transfer and stalls the master with HREADYOUTS low until the grant arrives.
- Returns the data-phase HREADYOUT/HRESP from the selected slave back to the master.

Parameters:
ADDR_WIDTH, 32, width of HADDR on master and matrix sides

Ports:
HCLK  input  1  AHB system clock
HRESETn  input  1  asynchronous active-low reset
HSELS  input  1  master-side select for this port
HADDRS  input  ADDR_WIDTH  master address
HTRANSS  input  2  master transfer type
HWRITES  input  1  master write
HSIZES  input  3  master size
HBURSTS  input  3  master burst
HPROTS  input  4  master protection
HMASTLOCKS  input  1  master lock
HREADYS  input  1  master-side bus HREADY (address-phase qualifier)
HREADYOUTS  output  1  ready returned to master
HRESPS  output  2  response returned to master
active_in  input  1  output stage has this port selected AND its HREADYM=1 this cycle
readyout_in  input  1  HREADYOUT of data-phase target slave
resp_in  input  2  HRESP of data-phase target slave
trans_pend  output  1  request to output arbiters (drives req_portN via decode)
HADDR_O  output  ADDR_WIDTH  address to matrix
HTRANS_O  output  2  transfer type to matrix
HWRITE_O  output  1  write to matrix
HSIZE_O  output  3  size to matrix
HBURST_O  output  3  burst to matrix
HPROT_O  output  4  prot to matrix
HMASTLOCK_O  output  1  lock to matrix

Behaviour:
- acc = HSELS & HREADYS & HTRANSS[1]. Only NONSEQ/SEQ are accepted; IDLE is never held.
- State machine with states IDLE, PEND, DATA. Reset state is IDLE.
- Hold registers (addr/trans/write/size/burst/prot/lock) reset to 0. They load only on capture, defined as acc & ~active_in in IDLE, or in DATA with readyout_in=1.
- IDLE transitions:
  - acc & active_in -> DATA.
  - acc & ~active_in -> PEND (capture).
  - otherwise stay IDLE.
- PEND transitions: active_in -> DATA; otherwise stay PEND.
- DATA transitions:
  - readyout_in=0 -> stay DATA.
  - readyout_in=1 & acc & active_in -> DATA.
  - readyout_in=1 & acc & ~active_in -> PEND (capture).
  - readyout_in=1 & no acc -> IDLE.
- HREADYOUTS/HRESPS by state:
  - IDLE: 1 / OKAY.
  - PEND: 0 / OKAY.
  - DATA: readyout_in / resp_in, combinational passthrough.
  - Two-cycle ERROR passes through unchanged.
- Matrix-side outputs:
  - In PEND: held values; HTRANS_O = held trans; trans_pend=1.
  - Otherwise: live master values, with HTRANS_O = acc ? HTRANSS : 2'b00, and trans_pend=acc.
  - BUSY (01) with HSELS & HREADYS & state!=PEND is forwarded as HTRANS_O=01 with trans_pend=0 and no state change.
- HMASTLOCK_O: held lock in PEND, HMASTLOCKS otherwise.
- Latency:
  - Granted transfer: zero added cycles.
  - Held transfer: forwarded in the first cycle active_in=1; the master sees HREADYOUTS=0 for every PEND cycle.
- In PEND the master cannot present a new address phase because HREADYOUTS=0. acc while in PEND is illegal; the bench flags it, and the RTL ignores it (hold regs unchanged).
- Asynchronous reset in any state: immediately IDLE, hold regs 0, HREADYOUTS=1, HRESPS=OKAY, trans_pend=0.

Test Plan:
- Granted pass-through: NONSEQ to 0x2000_0000 with active_in=1 -> HTRANS_O=10, HADDR_O=0x2000_0000 same cycle; next cycle DATA; HREADYOUTS follows readyout_in (0,0,1 -> 0,0,1); then IDLE.
- Held transfer: NONSEQ write 0x4000_0010 size=2 with active_in=0 for 3 cycles, then 1 -> PEND for 3 cycles with HREADYOUTS=0, trans_pend=1, HADDR_O=0x4000_0010 held while HADDRS changes; DATA follows the grant cycle.
- Back-to-back: in DATA, readyout_in=1 with new SEQ and active_in=0 -> PEND captures the SEQ (HTRANS_O=11 held); grant next cycle -> DATA.
- Error passthrough: DATA with resp_in=ERROR, readyout_in=0 then 1 -> HRESPS=ERROR both cycles, HREADYOUTS=0 then 1; master IDLE -> state IDLE.
- Reset mid-operation: assert HRESETn=0 while in PEND -> same-cycle trans_pend=0, HREADYOUTS=1, hold regs 0; after release, IDLE with no spurious request.
- IDLE/BUSY filtering: HTRANSS=00 with HSELS=1 -> HTRANS_O=00, trans_pend=0, no state change; BUSY in DATA -> HTRANS_O=01, trans_pend=0.

Source files
------------

// File: rtl/ahb_mtx_in_stage_if.sv
// Signal bundle for one master port of the AHB matrix input stage: the master-side
// bus, the feedback from the output stage and data-phase slave, and the matrix-side request.
interface ahb_mtx_in_stage_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  HSELS;
    logic [ADDR_WIDTH-1:0] HADDRS;
    logic [1:0]            HTRANSS;
    logic                  HWRITES;
    logic [2:0]            HSIZES;
    logic [2:0]            HBURSTS;
    logic [3:0]            HPROTS;
    logic                  HMASTLOCKS;
    logic                  HREADYS;
    logic                  HREADYOUTS;
    logic [1:0]            HRESPS;

    logic                  active_in;
    logic                  readyout_in;
    logic [1:0]            resp_in;

    logic                  trans_pend;
    logic [ADDR_WIDTH-1:0] HADDR_O;
    logic [1:0]            HTRANS_O;
    logic                  HWRITE_O;
    logic [2:0]            HSIZE_O;
    logic [2:0]            HBURST_O;
    logic [3:0]            HPROT_O;
    logic                  HMASTLOCK_O;

    // The input stage itself.
    modport slave (
        input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS, HREADYS,
        input  active_in, readyout_in, resp_in,
        output HREADYOUTS, HRESPS,
        output trans_pend, HADDR_O, HTRANS_O, HWRITE_O, HSIZE_O, HBURST_O, HPROT_O, HMASTLOCK_O
    );

    // The surroundings: master, output stage and data-phase slave.
    modport master (
        output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS, HREADYS,
        output active_in, readyout_in, resp_in,
        input  HREADYOUTS, HRESPS,
        input  trans_pend, HADDR_O, HTRANS_O, HWRITE_O, HSIZE_O, HBURST_O, HPROT_O, HMASTLOCK_O
    );
endinterface

// File: rtl/ahb_mtx_in_stage.sv
// Master-side input stage of the AHB bus matrix: forwards granted address phases at
// once, holds ungranted ones and stalls the master until the output stage selects this port.
module ahb_mtx_in_stage #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    ahb_mtx_in_stage_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PEND = 2'b01,
        ST_DATA = 2'b10
    } state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [1:0]            trans;
        logic                  write;
        logic [2:0]            size;
        logic [2:0]            burst;
        logic [3:0]            prot;
        logic                  lock;
    } addr_phase_t;

    localparam logic [1:0] TRANS_IDLE = 2'b00;
    localparam logic [1:0] TRANS_BUSY = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    state_t      state_q;
    state_t      state_d;
    addr_phase_t hold_q;
    addr_phase_t live;
    logic        acc;
    logic        busy_fwd;
    logic        capture;

    // Only NONSEQ/SEQ open a transfer; BUSY is passed along but never requests a slave.
    assign acc      = bus.HSELS & bus.HREADYS & bus.HTRANSS[1];
    assign busy_fwd = bus.HSELS & bus.HREADYS & (bus.HTRANSS == TRANS_BUSY);

    always_comb begin
        live.addr  = bus.HADDRS;
        live.trans = bus.HTRANSS;
        live.write = bus.HWRITES;
        live.size  = bus.HSIZES;
        live.burst = bus.HBURSTS;
        live.prot  = bus.HPROTS;
        live.lock  = bus.HMASTLOCKS;
    end

    // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (acc) begin
                    state_d = bus.active_in ? ST_DATA : ST_PEND;
                    capture = ~bus.active_in;
                end
            end
            ST_PEND: begin
                // The master is stalled here, so any acc seen now is ignored.
                if (bus.active_in) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bus.readyout_in) begin
                    if (acc) begin
                        state_d = bus.active_in ? ST_DATA : ST_PEND;
                        capture = ~bus.active_in;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state and hold registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hold_q <= '0;
        end else if (capture) begin
            hold_q <= live;
        end
    end

    // Matrix side shows the held phase while pending, the live master phase otherwise.
    always_comb begin
        bus.HADDR_O     = live.addr;
        bus.HWRITE_O    = live.write;
        bus.HSIZE_O     = live.size;
        bus.HBURST_O    = live.burst;
        bus.HPROT_O     = live.prot;
        bus.HMASTLOCK_O = live.lock;
        bus.HTRANS_O    = acc ? live.trans : (busy_fwd ? TRANS_BUSY : TRANS_IDLE);
        bus.trans_pend  = acc;
        bus.HREADYOUTS  = 1'b1;
        bus.HRESPS      = RESP_OKAY;
        unique case (state_q)
            ST_PEND: begin
                bus.HADDR_O     = hold_q.addr;
                bus.HTRANS_O    = hold_q.trans;
                bus.HWRITE_O    = hold_q.write;
                bus.HSIZE_O     = hold_q.size;
                bus.HBURST_O    = hold_q.burst;
                bus.HPROT_O     = hold_q.prot;
                bus.HMASTLOCK_O = hold_q.lock;
                bus.trans_pend  = 1'b1;
                bus.HREADYOUTS  = 1'b0;
            end
            ST_DATA: begin
                bus.HREADYOUTS = bus.readyout_in;
                bus.HRESPS     = bus.resp_in;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ahb_mtx_in_stage.sv
// Directed bench for ahb_mtx_in_stage: each scenario task drives one master/slave sequence
// and compares {HREADYOUTS, HRESPS, trans_pend, HTRANS_O} and held fields to hand-computed values.
module tb_ahb_mtx_in_stage;

    logic HCLK = 1'b0;
    logic HRESETn;
    int   vectors = 0;
    int   miscompares = 0;

    ahb_mtx_in_stage_if #(.ADDR_WIDTH(32)) bus ();

    ahb_mtx_in_stage #(.ADDR_WIDTH(32)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    always #5 HCLK = ~HCLK;

    // {HREADYOUTS, HRESPS, trans_pend, HTRANS_O}
    wire [5:0]  ctl  = {bus.HREADYOUTS, bus.HRESPS, bus.trans_pend, bus.HTRANS_O};
    wire [35:0] held = {bus.HADDR_O, bus.HWRITE_O, bus.HSIZE_O};

    // A new address phase while the master is being stalled is a bench stimulus error.
    always @(negedge HCLK) begin
        if (HRESETn === 1'b1 && bus.HREADYOUTS === 1'b0 && bus.HSELS && bus.HREADYS && bus.HTRANSS[1]) begin
            miscompares++;
            $display("FAIL illegal_acc_while_stalled: HREADYOUTS=%b HTRANSS=%b required no new address phase",
                     bus.HREADYOUTS, bus.HTRANSS);
        end
    end

    task automatic master(input logic sel, input logic [31:0] addr, input logic [1:0] trans,
                          input logic write, input logic [2:0] size, input logic rdy);
        bus.HSELS      = sel;
        bus.HADDRS     = addr;
        bus.HTRANSS    = trans;
        bus.HWRITES    = write;
        bus.HSIZES     = size;
        bus.HBURSTS    = 3'b001;
        bus.HPROTS     = 4'b0011;
        bus.HMASTLOCKS = 1'b0;
        bus.HREADYS    = rdy;
    endtask

    task automatic slave(input logic act, input logic rdy, input logic [1:0] resp);
        bus.active_in   = act;
        bus.readyout_in = rdy;
        bus.resp_in     = resp;
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic test_reset();
        logic [5:0] exp;
        HRESETn = 1'b0;
        master(1'b0, 32'h0, 2'b00, 1'b0, 3'd0, 1'b1);
        slave(1'b0, 1'b1, 2'b00);
        #3;
        exp = 6'b1_00_0_00; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL reset_state: ctl=%b required %b", ctl, exp); end
        repeat (2) @(posedge HCLK);
        #1 HRESETn = 1'b1;
        #3;
        exp = 6'b1_00_0_00; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL reset_release: ctl=%b required %b", ctl, exp); end
    endtask

    task automatic test_granted();
        logic [5:0] exp;
        tick(); master(1'b1, 32'h2000_0000, 2'b10, 1'b0, 3'd2, 1'b1); slave(1'b1, 1'b1, 2'b00); #3;
        exp = 6'b1_00_1_10; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL granted_addr_ctl: ctl=%b required %b", ctl, exp); end
        vectors++;
        if (bus.HADDR_O !== 32'h2000_0000) begin
            miscompares++; $display("FAIL granted_addr: HADDR_O=%h required 20000000", bus.HADDR_O);
        end
        tick(); master(1'b0, 32'h0, 2'b00, 1'b0, 3'd0, 1'b0); slave(1'b0, 1'b0, 2'b00); #3;
        exp = 6'b0_00_0_00; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL granted_wait1: ctl=%b required %b", ctl, exp); end
        tick(); #3;
        vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL granted_wait2: ctl=%b required %b", ctl, exp); end
        tick(); bus.HREADYS = 1'b1; slave(1'b0, 1'b1, 2'b00); #3;
        exp = 6'b1_00_0_00; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL granted_done: ctl=%b required %b", ctl, exp); end
        tick(); slave(1'b0, 1'b0, 2'b00); #3;
        vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL granted_back_idle: ctl=%b required %b", ctl, exp); end
    endtask

    task automatic test_held();
        logic [5:0]  exp;
        logic [35:0] dexp;
        dexp = {32'h4000_0010, 1'b1, 3'd2};
        tick(); master(1'b1, 32'h4000_0010, 2'b10, 1'b1, 3'd2, 1'b1); slave(1'b0, 1'b1, 2'b00); #3;
        exp = 6'b1_00_1_10; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL held_request: ctl=%b required %b", ctl, exp); end
        for (int i = 0; i < 3; i++) begin
            tick();
            master(1'b1, 32'hDEAD_BEE0 + 32'(i * 4), 2'b10, 1'b0, 3'd0, 1'b0);
            slave(i == 2, 1'b0, 2'b00);
            #3;
            exp = 6'b0_00_1_10; vectors++;
            if (ctl !== exp) begin miscompares++; $display("FAIL held_pend%0d_ctl: ctl=%b required %b", i, ctl, exp); end
            vectors++;
            if (held !== dexp) begin miscompares++; $display("FAIL held_pend%0d_fields: got %h required %h", i, held, dexp); end
        end
        tick(); master(1'b0, 32'h0, 2'b00, 1'b0, 3'd0, 1'b1); slave(1'b0, 1'b1, 2'b00); #3;
        exp = 6'b1_00_0_00; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL held_data: ctl=%b required %b", ctl, exp); end
        tick(); slave(1'b0, 1'b0, 2'b00); #3;
        vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL held_back_idle: ctl=%b required %b", ctl, exp); end
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp;
        tick(); master(1'b1, 32'h1000_0000, 2'b10, 1'b0, 3'd2, 1'b1); slave(1'b1, 1'b1, 2'b00); #3;
        exp = 6'b1_00_1_10; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL b2b_first: ctl=%b required %b", ctl, exp); end
        tick(); master(1'b1, 32'h1000_0004, 2'b11, 1'b0, 3'd2, 1'b1); slave(1'b0, 1'b1, 2'b00); #3;
        exp = 6'b1_00_1_11; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL b2b_seq_live: ctl=%b required %b", ctl, exp); end
        tick(); master(1'b1, 32'h1000_0008, 2'b11, 1'b0, 3'd2, 1'b0); slave(1'b1, 1'b0, 2'b00); #3;
        exp = 6'b0_00_1_11; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL b2b_seq_held: ctl=%b required %b", ctl, exp); end
        vectors++;
        if (bus.HADDR_O !== 32'h1000_0004) begin
            miscompares++; $display("FAIL b2b_addr_held: HADDR_O=%h required 10000004", bus.HADDR_O);
        end
        tick(); master(1'b0, 32'h0, 2'b00, 1'b0, 3'd0, 1'b1); slave(1'b0, 1'b1, 2'b00); #3;
        exp = 6'b1_00_0_00; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL b2b_data: ctl=%b required %b", ctl, exp); end
        tick(); slave(1'b0, 1'b0, 2'b00); #3;
        vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL b2b_back_idle: ctl=%b required %b", ctl, exp); end
    endtask

    task automatic test_error();
        logic [5:0] exp;
        tick(); master(1'b1, 32'h3000_0000, 2'b10, 1'b1, 3'd2, 1'b1); slave(1'b1, 1'b1, 2'b00); #3;
        exp = 6'b1_00_1_10; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL err_addr: ctl=%b required %b", ctl, exp); end
        tick(); master(1'b0, 32'h0, 2'b00, 1'b0, 3'd0, 1'b0); slave(1'b0, 1'b0, 2'b01); #3;
        exp = 6'b0_01_0_00; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL err_cycle1: ctl=%b required %b", ctl, exp); end
        tick(); bus.HREADYS = 1'b1; slave(1'b0, 1'b1, 2'b01); #3;
        exp = 6'b1_01_0_00; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL err_cycle2: ctl=%b required %b", ctl, exp); end
        tick(); slave(1'b0, 1'b0, 2'b01); #3;
        exp = 6'b1_00_0_00; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL err_back_idle: ctl=%b required %b", ctl, exp); end
    endtask

    task automatic test_reset_mid();
        logic [5:0] exp;
        tick(); master(1'b1, 32'h5000_0000, 2'b10, 1'b0, 3'd2, 1'b1); slave(1'b0, 1'b1, 2'b00); #3;
        exp = 6'b1_00_1_10; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL rst_request: ctl=%b required %b", ctl, exp); end
        tick(); master(1'b1, 32'h5000_0000, 2'b10, 1'b0, 3'd2, 1'b0); slave(1'b0, 1'b0, 2'b00); #3;
        exp = 6'b0_00_1_10; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL rst_pend: ctl=%b required %b", ctl, exp); end
        #1 HRESETn = 1'b0;
        #1;
        exp = 6'b1_00_0_00; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL rst_async: ctl=%b required %b", ctl, exp); end
        tick(); HRESETn = 1'b1; master(1'b0, 32'h0, 2'b00, 1'b0, 3'd0, 1'b1); slave(1'b1, 1'b0, 2'b00); #3;
        vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL rst_after1: ctl=%b required %b", ctl, exp); end
        tick(); #3;
        vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL rst_after2: ctl=%b required %b", ctl, exp); end
    endtask

    task automatic test_idle_busy();
        logic [5:0] exp;
        tick(); master(1'b1, 32'h6000_0000, 2'b00, 1'b0, 3'd2, 1'b1); slave(1'b1, 1'b1, 2'b00); #3;
        exp = 6'b1_00_0_00; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL ib_idle_filtered: ctl=%b required %b", ctl, exp); end
        tick(); bus.HTRANSS = 2'b01; slave(1'b0, 1'b0, 2'b00); #3;
        exp = 6'b1_00_0_01; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL ib_busy_in_idle: ctl=%b required %b", ctl, exp); end
        tick(); bus.HTRANSS = 2'b10; slave(1'b1, 1'b0, 2'b00); #3;
        exp = 6'b1_00_1_10; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL ib_nonseq: ctl=%b required %b", ctl, exp); end
        tick(); bus.HTRANSS = 2'b01; slave(1'b0, 1'b1, 2'b00); #3;
        exp = 6'b1_00_0_01; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL ib_busy_in_data: ctl=%b required %b", ctl, exp); end
        tick(); master(1'b0, 32'h0, 2'b00, 1'b0, 3'd0, 1'b1); slave(1'b0, 1'b0, 2'b00); #3;
        exp = 6'b1_00_0_00; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL ib_back_idle: ctl=%b required %b", ctl, exp); end
    endtask

    initial begin
        test_reset();
        test_granted();
        test_held();
        test_back_to_back();
        test_error();
        test_reset_mid();
        test_idle_busy();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
